player_hp_manager: RTL and testbench
====================================

Name: player_hp_manager

Overview:
Downstream consumer of the per-frame damage calculator. Once per frame it pulses start to the calculator and waits for isComplete. It then applies the reported damage and heal to the player HP register, with saturation, invulnerability frames and game-over detection. The HP bar renderer and the game-state controller read its hp and isDead outputs.

Parameters:
MAX_HP, 92, HP after reset/newGame and heal ceiling (8-bit, 1..255)
HEAL_AMOUNT, 20, HP restored when heal=1 in a completed frame
IFRAME_FRAMES, 30, frames of invulnerability after damage is applied (0 disables)
CALC_TIMEOUT, 16, clk cycles to wait for isComplete before abandoning a frame

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
frameTick  input  1  one-cycle pulse per video frame; requests a damage evaluation
newGame  input  1  one-cycle pulse; restores HP and leaves DEAD
damage  input  8  accumulated damage from calculator, valid when isComplete=1
heal  input  1  heal flag from calculator, valid when isComplete=1
isComplete  input  1  one-cycle done pulse from calculator
start  output  1  one-cycle pulse to calculator
hp  output  8  current player HP
isDead  output  1  high while hp=0 (DEAD state)
invuln  output  1  high while invulnerability counter is non-zero (drives sprite blink)
hpChanged  output  1  one-cycle pulse when hp value changes
overrun  output  1  sticky: frameTick arrived while not IDLE, or timeout occurred; cleared by newGame/reset

Behaviour:
- Reset (rst_n=0, async): hp=MAX_HP, state=IDLE, start=0, isDead=0, invuln=0, iframe counter=0, hpChanged=0, overrun=0, timeout counter=0.
- States: IDLE, WAIT_CALC, APPLY, DEAD.
- IDLE: frameTick=1 -> start=1 for exactly that next cycle, timeout counter cleared, go to WAIT_CALC.
- WAIT_CALC: isComplete=1 -> latch damage/heal, go to APPLY. No isComplete after CALC_TIMEOUT cycles -> set overrun, go to IDLE, hp unchanged.
- APPLY (exactly 1 cycle), in this order:
  - Damage: applied only if damage!=0 and iframe counter==0. Then hp = (damage>=hp) ? 0 : hp-damage, and iframe counter = IFRAME_FRAMES. If invulnerable, damage is discarded.
  - Heal: applied after damage if heal=1 and the post-damage hp!=0. hp = min(hp+HEAL_AMOUNT, MAX_HP), computed on 9 bits.
  - Exit: resulting hp==0 -> DEAD; otherwise IDLE.
  - hpChanged pulses in the cycle after APPLY iff the final hp differs from the pre-APPLY hp.
- Frame rule: at most one start per frame. A frameTick seen outside IDLE sets overrun and is otherwise ignored; it is not queued.
- Invulnerability counter: decrements by 1 on each frameTick while non-zero, in any state except DEAD. invuln = (counter!=0). Reload in APPLY takes priority over a same-cycle decrement.
- DEAD: isDead=1, hp=0, start never asserted, calculator inputs ignored.
- newGame: priority over everything, in any state. Next cycle: hp=MAX_HP, counters and overrun cleared, state=IDLE. hpChanged pulses if hp was not MAX_HP.
- Latency: frameTick -> start is 1 cycle. isComplete -> hp update is 2 cycles (latch, APPLY).

Decomposition:
- Shared package (game_pkg): state encoding constants (IDLE/WAIT_CALC/APPLY/DEAD), HP width (8), default MAX_HP and attack/heal constants, so the calculator's attackPower and this block agree.
- One natural sub-module: iframe_counter, a frame-tick down-counter with load and non-zero flag. Everything else stays in this module.

Test Plan:
- Reset, then frameTick; calculator returns damage=10, heal=0 -> start pulses 1 cycle after tick; hp 92->82 two cycles after isComplete; hpChanged pulses once; invuln=1 for the next 30 frameTicks.
- During invulnerability, frame with damage=20 -> hp stays 82, no hpChanged; after 30 ticks invuln=0, and damage=20 -> hp=62.
- hp=85, frame with damage=0, heal=1 -> hp=92 (clamped, not 105). At hp=92, heal=1 -> no hpChanged.
- hp=15, damage=30 -> hp=0, isDead=1; further frameTicks produce no start. newGame -> hp=92, isDead=0, state IDLE.
- frameTick with isComplete never returned -> overrun=1 after 16 cycles, hp unchanged; next frameTick gets a fresh start. A frameTick issued while in WAIT_CALC also sets overrun.
- hp=10, damage=10 and heal=1 in the same frame -> hp=0 and DEAD (heal is not applied after death); assert rst_n low mid-WAIT_CALC -> outputs immediately at reset values.

Source files
------------

// File: rtl/player_hp_manager_pkg.sv
// Shared game constants and types for the HP manager and the damage calculator.
package player_hp_manager_pkg;

    localparam int unsigned HP_W              = 8;
    localparam int unsigned DEF_MAX_HP        = 92;
    localparam int unsigned DEF_HEAL_AMOUNT   = 20;
    localparam int unsigned DEF_IFRAME_FRAMES = 30;
    localparam int unsigned DEF_CALC_TIMEOUT  = 16;
    localparam int unsigned DEF_ATTACK_POWER  = 10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_CALC = 2'd1,
        ST_APPLY     = 2'd2,
        ST_DEAD      = 2'd3
    } hp_state_e;

    typedef struct packed {
        logic [HP_W-1:0] damage;
        logic            heal;
    } calc_result_t;

    // Heal with a ceiling; the sum is formed one bit wider so it cannot wrap.
    function automatic logic [HP_W-1:0] sat_heal(input logic [HP_W-1:0] hp,
                                                 input logic [HP_W-1:0] amount,
                                                 input logic [HP_W-1:0] max_hp);
        logic [HP_W:0] sum;
        sum = {1'b0, hp} + {1'b0, amount};
        return (sum > {1'b0, max_hp}) ? max_hp : sum[HP_W-1:0];
    endfunction

endpackage

// File: rtl/player_hp_manager_if.sv
// Frame/calculator handshake and HP status bundle of the player HP manager.
interface player_hp_manager_if;
    import player_hp_manager_pkg::*;

    logic            frameTick;
    logic            newGame;
    logic [HP_W-1:0] damage;
    logic            heal;
    logic            isComplete;
    logic            start;
    logic [HP_W-1:0] hp;
    logic            isDead;
    logic            invuln;
    logic            hpChanged;
    logic            overrun;

    modport master (
        output frameTick, newGame, damage, heal, isComplete,
        input  start, hp, isDead, invuln, hpChanged, overrun
    );

    modport slave (
        input  frameTick, newGame, damage, heal, isComplete,
        output start, hp, isDead, invuln, hpChanged, overrun
    );

endinterface

// File: rtl/player_hp_manager_iframe_counter.sv
// Frame-tick down-counter for invulnerability frames, with load and registered non-zero flag.
module iframe_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    input  logic             hold,
    output logic             active
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    // Clear beats load, load beats a same-cycle tick.
    always_comb begin
        cnt_nxt = cnt_q;
        if (clr) begin
            cnt_nxt = '0;
        end else if (load) begin
            cnt_nxt = load_val;
        end else if (tick && !hold && (cnt_q != '0)) begin
            cnt_nxt = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            active <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            active <= (cnt_nxt != '0);
        end
    end

endmodule

// File: rtl/player_hp_manager.sv
// Per-frame HP bookkeeping: requests a damage evaluation, applies damage/heal, tracks death.
module player_hp_manager
    import player_hp_manager_pkg::*;
#(
    parameter int unsigned MAX_HP        = DEF_MAX_HP,
    parameter int unsigned HEAL_AMOUNT   = DEF_HEAL_AMOUNT,
    parameter int unsigned IFRAME_FRAMES = DEF_IFRAME_FRAMES,
    parameter int unsigned CALC_TIMEOUT  = DEF_CALC_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    player_hp_manager_if.slave  bus
);

    localparam int unsigned TO_W = (CALC_TIMEOUT > 1) ? $clog2(CALC_TIMEOUT) : 1;

    hp_state_e       state_q;
    logic [TO_W-1:0] tcnt_q;
    calc_result_t    calc_q;
    logic [HP_W-1:0] hp_q;
    logic            start_q;
    logic            dead_q;
    logic            hpchg_q;
    logic            overrun_q;
    logic            invuln_q;

    logic            dmg_hit;
    logic [HP_W-1:0] hp_dmg;
    logic [HP_W-1:0] hp_apply;

    // Damage first, then heal only if the player survived it.
    always_comb begin
        dmg_hit  = (calc_q.damage != '0) && !invuln_q;
        hp_dmg   = hp_q;
        if (dmg_hit) begin
            hp_dmg = (calc_q.damage >= hp_q) ? '0 : (hp_q - calc_q.damage);
        end
        hp_apply = hp_dmg;
        if (calc_q.heal && (hp_dmg != '0)) begin
            hp_apply = sat_heal(hp_dmg, HP_W'(HEAL_AMOUNT), HP_W'(MAX_HP));
        end
    end

    iframe_counter #(
        .CNT_W (HP_W)
    ) u_iframe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.newGame),
        .load     ((state_q == ST_APPLY) && dmg_hit),
        .load_val (HP_W'(IFRAME_FRAMES)),
        .tick     (bus.frameTick),
        .hold     (state_q == ST_DEAD),
        .active   (invuln_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tcnt_q    <= '0;
            calc_q    <= '0;
            hp_q      <= HP_W'(MAX_HP);
            start_q   <= 1'b0;
            dead_q    <= 1'b0;
            hpchg_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            hpchg_q <= 1'b0;
            if (bus.newGame) begin
                state_q   <= ST_IDLE;
                tcnt_q    <= '0;
                hp_q      <= HP_W'(MAX_HP);
                dead_q    <= 1'b0;
                overrun_q <= 1'b0;
                hpchg_q   <= (hp_q != HP_W'(MAX_HP));
            end else begin
                // A tick outside IDLE is dropped, only flagged.
                if (bus.frameTick && (state_q != ST_IDLE)) begin
                    overrun_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (bus.frameTick) begin
                            start_q <= 1'b1;
                            tcnt_q  <= '0;
                            state_q <= ST_WAIT_CALC;
                        end
                    end
                    ST_WAIT_CALC: begin
                        if (bus.isComplete) begin
                            calc_q.damage <= bus.damage;
                            calc_q.heal   <= bus.heal;
                            state_q       <= ST_APPLY;
                        end else if (tcnt_q == TO_W'(CALC_TIMEOUT - 1)) begin
                            overrun_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            tcnt_q <= tcnt_q + TO_W'(1);
                        end
                    end
                    ST_APPLY: begin
                        hp_q    <= hp_apply;
                        hpchg_q <= (hp_apply != hp_q);
                        if (hp_apply == '0) begin
                            dead_q  <= 1'b1;
                            state_q <= ST_DEAD;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DEAD: begin
                        state_q <= ST_DEAD;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.start     = start_q;
    assign bus.hp        = hp_q;
    assign bus.isDead    = dead_q;
    assign bus.invuln    = invuln_q;
    assign bus.hpChanged = hpchg_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_player_hp_manager.sv
// Randomized frame-level bench for player_hp_manager against a rule-based HP model.
module tb_player_hp_manager;

    localparam int MAX_HP  = 92;
    localparam int HEAL    = 20;
    localparam int IFRAMES = 30;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_n;

    player_hp_manager_if bus();

    player_hp_manager dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    int m_hp;
    int m_ifr;
    bit m_dead;
    bit m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_hp   = MAX_HP;
        m_ifr  = 0;
        m_dead = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_tick();
        if (!m_dead && m_ifr > 0) m_ifr--;
    endtask

    task automatic check_state();
        check("hp",      32'(bus.hp),      32'(m_hp));
        check("isDead",  32'(bus.isDead),  32'(m_dead));
        check("invuln",  32'(bus.invuln),  32'(m_ifr != 0));
        check("overrun", 32'(bus.overrun), 32'(m_ovr));
    endtask

    task automatic do_frame(input int dmg, input bit hl, input bit stray);
        int pre;
        int d;
        bus.frameTick = 1'b1;
        step();
        bus.frameTick = 1'b0;
        if (m_dead) begin
            m_ovr = 1'b1;
            check("start_dead", 32'(bus.start), 32'd0);
            step();
            check("start_dead", 32'(bus.start), 32'd0);
            check_state();
            return;
        end
        model_tick();
        check("start", 32'(bus.start), 32'd1);
        check_state();
        step();
        check("start_len", 32'(bus.start), 32'd0);
        if (stray) begin
            bus.frameTick = 1'b1;
            step();
            bus.frameTick = 1'b0;
            m_ovr = 1'b1;
            model_tick();
        end
        d = int'($urandom_range(0, 4));
        for (int i = 0; i < d; i++) step();
        bus.damage     = 8'(dmg);
        bus.heal       = hl;
        bus.isComplete = 1'b1;
        step();
        bus.isComplete = 1'b0;
        bus.damage     = 8'($urandom);
        bus.heal       = 1'($urandom);
        step();
        pre = m_hp;
        if (dmg != 0 && m_ifr == 0) begin
            m_hp  = (dmg >= m_hp) ? 0 : m_hp - dmg;
            m_ifr = IFRAMES;
        end
        if (hl && m_hp != 0) m_hp = (m_hp + HEAL > MAX_HP) ? MAX_HP : m_hp + HEAL;
        m_dead = (m_hp == 0);
        check("hpChanged", 32'(bus.hpChanged), 32'(m_hp != pre));
        check_state();
        step();
        check("hpChanged_len", 32'(bus.hpChanged), 32'd0);
    endtask

    task automatic do_timeout();
        bus.frameTick = 1'b1;
        step();
        bus.frameTick = 1'b0;
        model_tick();
        check("start_to", 32'(bus.start), 32'd1);
        for (int k = 1; k < TIMEOUT; k++) step();
        check("overrun_early", 32'(bus.overrun), 32'(m_ovr));
        step();
        m_ovr = 1'b1;
        check_state();
    endtask

    task automatic do_newgame();
        int pre;
        pre = m_hp;
        bus.newGame = 1'b1;
        step();
        bus.newGame = 1'b0;
        model_reset();
        check("hpChanged_ng", 32'(bus.hpChanged), 32'(pre != MAX_HP));
        check_state();
        step();
        check("hpChanged_ng_len", 32'(bus.hpChanged), 32'd0);
    endtask

    task automatic do_reset_mid();
        bus.frameTick = 1'b1;
        step();
        bus.frameTick = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_start",     32'(bus.start),     32'd0);
        check("rst_hpChanged", 32'(bus.hpChanged), 32'd0);
        check_state();
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic drain_iframes();
        for (int i = 0; i < 2 * IFRAMES && m_ifr > 1; i++) do_frame(0, 1'b0, 1'b0);
    endtask

    initial begin
        int r;
        int dmg;
        bit hl;
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.frameTick = 1'b0;
        bus.newGame   = 1'b0;
        bus.damage    = '0;
        bus.heal      = 1'b0;
        bus.isComplete = 1'b0;
        model_reset();
        step();
        step();
        check("rst_start",     32'(bus.start),     32'd0);
        check("rst_hpChanged", 32'(bus.hpChanged), 32'd0);
        check_state();
        rst_n = 1'b1;
        step();

        // First hit, then a hit absorbed by invulnerability, then a hit once it expires.
        do_frame(10, 1'b0, 1'b0);
        check("hp_first_hit", 32'(bus.hp), 32'd82);
        do_frame(20, 1'b0, 1'b0);
        check("hp_invuln", 32'(bus.hp), 32'd82);
        drain_iframes();
        do_frame(20, 1'b0, 1'b0);
        check("hp_after_iframes", 32'(bus.hp), 32'd62);

        // Heal clamps at the ceiling; healing at full HP is silent.
        do_newgame();
        do_frame(7, 1'b0, 1'b0);
        do_frame(0, 1'b1, 1'b0);
        check("hp_heal_clamp", 32'(bus.hp), 32'd92);
        do_frame(0, 1'b1, 1'b0);

        // Lethal hit, frames while dead, revival.
        do_newgame();
        do_frame(77, 1'b0, 1'b0);
        drain_iframes();
        do_frame(30, 1'b0, 1'b0);
        check("dead_flag", 32'(bus.isDead), 32'd1);
        do_frame(5, 1'b1, 1'b0);
        do_newgame();

        // Calculator silence, stray tick during wait.
        do_timeout();
        do_frame(3, 1'b0, 1'b1);

        // Exactly lethal damage with heal in the same frame stays dead.
        do_newgame();
        do_frame(82, 1'b0, 1'b0);
        drain_iframes();
        do_frame(10, 1'b1, 1'b0);
        check("dead_no_heal", 32'(bus.hp), 32'd0);
        do_newgame();

        do_reset_mid();

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            dmg = ($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(1, 60));
            if ($urandom_range(0, 19) == 0) dmg = int'($urandom_range(200, 255));
            hl = ($urandom_range(0, 99) < 35);
            if (m_dead) begin
                if (r < 60) do_newgame();
                else do_frame(dmg, hl, 1'b0);
            end else if (r < 4) begin
                do_reset_mid();
            end else if (r < 10) begin
                do_timeout();
            end else if (r < 14) begin
                do_newgame();
            end else begin
                do_frame(dmg, hl, ($urandom_range(0, 9) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
